act_fetch: RTL and testbench

//  Reads 4-bit quantized activation vectors (16 lanes x 4b) from the output RAM that the PPU

---
 rtl/act_fetch.sv | 151 +++++++++++++++
 tb/tb_act_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/act_fetch.sv
// act_fetch: streams 16x4b activation words from the PPU output RAM to the PE array.
// Optional ACT_FETCH_STALL_CNT_EN adds o_stall_cnt (backpressure cycles per transfer).
module act_fetch #(
    parameter int LANES  = 16,
    parameter int Q_W    = 4,
    parameter int ADDR_W = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ADDR_W-1:0]      i_base_addr,
    input  logic [ADDR_W:0]        i_len,
    output logic                   o_ram_re,
    output logic [ADDR_W-1:0]      o_ram_addr,
    input  logic [LANES*Q_W-1:0]   i_ram_data,
    output logic                   o_valid,
    output logic [LANES*Q_W-1:0]   o_data,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic                   o_done
`ifdef ACT_FETCH_STALL_CNT_EN
   ,output logic [15:0]            o_stall_cnt
`endif
);

    localparam int D_W = LANES * Q_W;
    localparam logic [ADDR_W:0] ONE = 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_left;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   beat_cnt;
    logic              inflight;
    logic              done_q;

    logic [D_W-1:0]    mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;

    logic              start_ok;
    logic              push;
    logic              pop;
    logic              last_rd;
    logic [2:0]        credit;

    assign start_ok = (state == S_IDLE) && i_start;
    assign push     = inflight;
    assign pop      = o_valid && i_ready;

    // The slot freed by this cycle's pop is reusable now, so one beat/cycle sustains.
    assign credit   = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
    assign o_ram_re = (state == S_FETCH) && (credit < 3'd2);
    assign last_rd  = o_ram_re && (rd_left == ONE);

    assign o_ram_addr = rd_addr;
    assign o_valid    = (fifo_cnt != 2'd0);
    assign o_data     = o_valid ? mem[rd_ptr] : '0;
    assign o_busy     = (state != S_IDLE);
    assign o_done     = done_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_start && (i_len != '0))
                        state <= S_FETCH;
                end
                S_FETCH: begin
                    if (last_rd)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if ((fifo_cnt == 2'd0) && !inflight)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_addr  <= '0;
            rd_left  <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            inflight <= o_ram_re;
            if (start_ok) begin
                rd_addr  <= i_base_addr;
                rd_left  <= i_len;
                len_q    <= i_len;
                beat_cnt <= '0;
            end else begin
                if (o_ram_re) begin
                    rd_addr <= rd_addr + 1'b1;
                    rd_left <= rd_left - ONE;
                end
                if (pop)
                    beat_cnt <= beat_cnt + ONE;
            end
            done_q <= (start_ok && (i_len == '0))
                   || (o_busy && pop && ((beat_cnt + ONE) == len_q));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= i_ram_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

`ifdef ACT_FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (o_busy && o_valid && !i_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_act_fetch.sv
// tb_act_fetch: scoreboard bench for act_fetch with a 1-cycle-latency RAM model.
// Expected beats/addresses are queued at start and popped as the DUT produces them.
module tb_act_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  base_addr;
    logic [6:0]  len;
    logic        ram_re;
    logic [5:0]  ram_addr;
    logic [63:0] ram_data;
    logic        valid;
    logic [63:0] data;
    logic        ready;
    logic        busy;
    logic        done;
`ifdef ACT_FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    act_fetch dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_len       (len),
        .o_ram_re    (ram_re),
        .o_ram_addr  (ram_addr),
        .i_ram_data  (ram_data),
        .o_valid     (valid),
        .o_data      (data),
        .i_ready     (ready),
        .o_busy      (busy),
        .o_done      (done)
`ifdef ACT_FETCH_STALL_CNT_EN
       ,.o_stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [63:0] ram [64];
    always @(posedge clk) if (ram_re) ram_data <= ram[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [63:0] exp_q [$];
    logic [5:0]  addr_q [$];

    int t0, n_reads, n_beats, n_done, n_stall;
    int first_re, first_val, last_beat, done_rel, idle_rel;
    bit hold_chk;
    logic [63:0] held;

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        if (hold_chk && rst_n) chk("hold", data, held);
        hold_chk = valid && !ready;
        held     = data;
        if (ram_re) begin
            n_reads++;
            if (first_re < 0) first_re = rel;
            if (addr_q.size() == 0) chk("rd_extra", 64'(ram_addr), 64'hX);
            else chk("rd_addr", 64'(ram_addr), 64'(addr_q.pop_front()));
        end
        if (valid && ready) begin
            n_beats++;
            last_beat = rel;
            if (first_val < 0) first_val = rel;
            if (exp_q.size() == 0) chk("beat_extra", data, 64'hX);
            else chk("beat", data, exp_q.pop_front());
        end
        if (busy && valid && !ready) n_stall++;
        if (done) begin
            n_done++;
            done_rel = rel;
        end
        if (n_done > 0 && !busy && idle_rel < 0) idle_rel = rel;
    end

    function automatic logic rdy_for(input int mode, input int rel);
        case (mode)
            1:       return (rel % 2) == 0;
            2:       return rel > 20;
            default: return 1'b1;
        endcase
    endfunction

    task automatic launch(input logic [5:0] b, input logic [6:0] l, input int mode);
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < int'(l); i++) begin
            addr_q.push_back(6'(int'(b) + i));
            exp_q.push_back(ram[6'(int'(b) + i)]);
        end
        n_reads = 0; n_beats = 0; n_done = 0; n_stall = 0;
        first_re = -1; first_val = -1; last_beat = -1;
        done_rel = -1; idle_rel = -1;
        @(posedge clk); #2;
        t0 = cyc;
        base_addr = b;
        len = l;
        start = 1'b1;
        ready = rdy_for(mode, 0);
    endtask

    int reads_at20;
    bit valid_at20;

    task automatic wait_done(input int mode, input string tag);
        int rel;
        int guard;
        guard = 0;
        while (n_done == 0 && guard < 600) begin
            @(posedge clk); #2;
            guard++;
            rel = cyc - t0;
            start = (mode == 2 && rel == 10);
            base_addr = 6'($urandom);
            len = 7'($urandom_range(1, 64));
            ready = rdy_for(mode, rel);
            if (rel == 20) begin
                reads_at20 = n_reads;
                valid_at20 = valid;
            end
        end
        if (n_done == 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk({tag, "_done_cnt"}, 64'(n_done), 64'd1);
        chk({tag, "_left_beats"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_left_addrs"}, 64'(addr_q.size()), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = {$urandom, $urandom};
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; ready = 1'b1;
        t0 = 0; hold_chk = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_re", 64'(ram_re), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        launch(6'd0, 7'd16, 0);
        wait_done(0, "lin");
        chk("lin_beats", 64'(n_beats), 64'd16);
        chk("lin_first_re", 64'(first_re), 64'd1);
        chk("lin_first_val", 64'(first_val), 64'd3);
        chk("lin_last_beat", 64'(last_beat), 64'd18);
        chk("lin_done_cyc", 64'(done_rel), 64'd19);
        chk("lin_idle_cyc", 64'(idle_rel), 64'd20);

        launch(6'd60, 7'd8, 0);
        wait_done(0, "wrap");
        chk("wrap_beats", 64'(n_beats), 64'd8);

        launch(6'd17, 7'd64, 1);
        wait_done(1, "tog");
        chk("tog_beats", 64'(n_beats), 64'd64);
        chk("tog_reads", 64'(n_reads), 64'd64);
`ifdef ACT_FETCH_STALL_CNT_EN
        chk("tog_stall_cnt", 64'(stall_cnt), 64'(n_stall));
`endif

        launch(6'd40, 7'd4, 2);
        wait_done(2, "stl");
        chk("stl_reads20", 64'(reads_at20), 64'd2);
        chk("stl_valid20", 64'(valid_at20), 64'd1);
        chk("stl_beats", 64'(n_beats), 64'd4);
        chk("stl_reads", 64'(n_reads), 64'd4);

        launch(6'd5, 7'd0, 0);
        wait_done(0, "zero");
        chk("zero_done_cyc", 64'(done_rel), 64'd1);
        chk("zero_reads", 64'(n_reads), 64'd0);
        chk("zero_beats", 64'(n_beats), 64'd0);

        launch(6'd0, 7'd16, 0);
        begin
            int guard;
            guard = 0;
            while (n_beats < 5 && guard < 100) begin
                @(posedge clk); #2;
                start = 1'b0;
                guard++;
            end
            if (n_beats < 5) chk("abort_timeout", 64'd0, 64'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_re", 64'(ram_re), 64'd0);
        chk("abort_addr", 64'(ram_addr), 64'd0);
        chk("abort_valid", 64'(valid), 64'd0);
        chk("abort_data", data, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        launch(6'd0, 7'd2, 0);
        wait_done(0, "post");
        chk("post_beats", 64'(n_beats), 64'd2);
        chk("post_reads", 64'(n_reads), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
